// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive line decoder.
package usb_rx_pkg;

    typedef enum logic [1:0] {J, K, SE0, SE1} line_state_t;
    typedef enum logic [1:0] {IDLE, RX, WAIT_IDLE} rx_state_t;

    localparam int   USB_STUFF_LEN = 6;
    localparam logic USB_J_DP      = 1'b1;

    function automatic line_state_t decode_line(input logic dp, input logic dm);
        case ({dp, dm})
            2'b10:   decode_line = J;
            2'b01:   decode_line = K;
            2'b00:   decode_line = SE0;
            default: decode_line = SE1;
        endcase
    endfunction

endpackage

// File: rtl/usb_rx_bit_timer.sv
// Bit-clock recovery: a free-running bit counter realigned on every D+ edge,
// strobing a sample at mid-bit.
module usb_rx_bit_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic dp_sync,
    output logic sample
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2);

    logic [CNT_W-1:0] cnt;
    logic             dp_sync_d;
    logic             edge_det;

    assign edge_det = (dp_sync != dp_sync_d);
    // An edge landing on the mid-bit slot suppresses that sample.
    assign sample   = (cnt == CNT_MID) && !edge_det;

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_sync_d <= USB_J_DP;
            cnt       <= '0;
        end else begin
            dp_sync_d <= dp_sync;
            if (edge_det || cnt == CNT_LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/usb_rx_decoder.sv
// USB full-speed receive decoder: pin synchronizers, line-state decode, NRZI
// decode, bit unstuffing and EOP detection feeding flex_sr.
module usb_rx_decoder
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int SE0_EOP_BITS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic dp_in,
    input  logic dm_in,
    output logic shift_enable,
    output logic serial_in,
    output logic eop,
    output logic rx_err,
    output logic rx_busy
);

    localparam int SE0_W = $clog2(SE0_EOP_BITS + 1);
    localparam logic [SE0_W-1:0] SE0_FULL   = SE0_W'(SE0_EOP_BITS);
    localparam logic [2:0]       STUFF_FULL = 3'(USB_STUFF_LEN);

    logic        dp_meta, dp_sync, dm_meta, dm_sync;
    logic        sample;
    line_state_t ls;
    rx_state_t   state;
    logic        prev_dp;
    logic        nrzi_bit;
    logic [2:0]  ones;
    logic [SE0_W-1:0] se0_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_meta <= USB_J_DP;
            dp_sync <= USB_J_DP;
            dm_meta <= ~USB_J_DP;
            dm_sync <= ~USB_J_DP;
        end else begin
            dp_meta <= dp_in;
            dp_sync <= dp_meta;
            dm_meta <= dm_in;
            dm_sync <= dm_meta;
        end
    end

    usb_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .dp_sync (dp_sync),
        .sample  (sample)
    );

    assign ls       = decode_line(dp_sync, dm_sync);
    assign nrzi_bit = (dp_sync == prev_dp);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            prev_dp      <= USB_J_DP;
            ones         <= '0;
            se0_cnt      <= '0;
            shift_enable <= 1'b0;
            serial_in    <= 1'b1;
            eop          <= 1'b0;
            rx_err       <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            shift_enable <= 1'b0;
            eop          <= 1'b0;
            rx_err       <= 1'b0;
            if (sample) begin
                case (state)
                    IDLE: begin
                        if (ls == K) begin
                            // First K decodes against an implied J, yielding 0.
                            state        <= RX;
                            rx_busy      <= 1'b1;
                            prev_dp      <= dp_sync;
                            ones         <= '0;
                            se0_cnt      <= '0;
                            shift_enable <= 1'b1;
                            serial_in    <= (dp_sync == USB_J_DP);
                        end
                    end
                    RX: begin
                        case (ls)
                            SE0: begin
                                if (se0_cnt != SE0_FULL)
                                    se0_cnt <= se0_cnt + 1'b1;
                            end
                            SE1: begin
                                state   <= WAIT_IDLE;
                                rx_err  <= 1'b1;
                                se0_cnt <= '0;
                            end
                            default: begin
                                if (se0_cnt == SE0_FULL) begin
                                    se0_cnt <= '0;
                                    if (ls == J) begin
                                        state   <= IDLE;
                                        eop     <= 1'b1;
                                        rx_busy <= 1'b0;
                                    end else begin
                                        state  <= WAIT_IDLE;
                                        rx_err <= 1'b1;
                                    end
                                end else if (se0_cnt != '0) begin
                                    state   <= WAIT_IDLE;
                                    rx_err  <= 1'b1;
                                    se0_cnt <= '0;
                                end else begin
                                    prev_dp <= dp_sync;
                                    if (ones == STUFF_FULL) begin
                                        if (nrzi_bit) begin
                                            state  <= WAIT_IDLE;
                                            rx_err <= 1'b1;
                                        end else begin
                                            ones <= '0;
                                        end
                                    end else begin
                                        shift_enable <= 1'b1;
                                        serial_in    <= nrzi_bit;
                                        ones         <= nrzi_bit ? ones + 3'd1 : 3'd0;
                                    end
                                end
                            end
                        endcase
                    end
                    WAIT_IDLE: begin
                        case (ls)
                            SE0: begin
                                if (se0_cnt != SE0_FULL)
                                    se0_cnt <= se0_cnt + 1'b1;
                            end
                            J: begin
                                se0_cnt <= '0;
                                if (se0_cnt == SE0_FULL) begin
                                    state   <= IDLE;
                                    rx_busy <= 1'b0;
                                end
                            end
                            default: se0_cnt <= '0;
                        endcase
                    end
                    default: begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Self-checking bench: packets are built, bit-stuffed and NRZI-encoded onto the
// pins by a line model; decoded strobes are captured and compared per scenario.
module tb_usb_rx_decoder;

    localparam int CPB  = 8;
    localparam int EOPB = 2;

    logic clk = 1'b0;
    logic rst, dp_in, dm_in;
    logic shift_enable, serial_in, eop, rx_err, rx_busy;

    usb_rx_decoder #(.CLKS_PER_BIT(CPB), .SE0_EOP_BITS(EOPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .dp_in        (dp_in),
        .dm_in        (dm_in),
        .shift_enable (shift_enable),
        .serial_in    (serial_in),
        .eop          (eop),
        .rx_err       (rx_err),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] byte_q[$];
    bit data_q[$];
    bit wire_q[$];
    bit stuffed_q[$];
    bit got[$];

    int eop_cnt, err_cnt, coinc_cnt, wide_cnt, busy_bad;
    int cyc = 0;
    int last_se, min_gap;
    logic prev_eop = 1'b0, prev_err = 1'b0, prev_se = 1'b0;
    int mode = 0;
    bit phase = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (shift_enable) begin
            got.push_back(serial_in);
            if (last_se >= 0 && (cyc - last_se) < min_gap) min_gap = cyc - last_se;
            last_se = cyc;
        end
        if (eop) begin
            eop_cnt++;
            if (rx_busy) busy_bad++;
        end
        if (rx_err) err_cnt++;
        if ((shift_enable && (eop || rx_err)) || (eop && rx_err)) coinc_cnt++;
        if ((eop && prev_eop) || (rx_err && prev_err) || (shift_enable && prev_se)) wide_cnt++;
        prev_eop = eop;
        prev_err = rx_err;
        prev_se  = shift_enable;
    end

    task automatic clear_mon();
        got.delete();
        eop_cnt = 0; err_cnt = 0; coinc_cnt = 0; wide_cnt = 0; busy_bad = 0;
        last_se = -1; min_gap = 1000;
    endtask

    task automatic next_len(output int len);
        if (mode == 0) len = CPB;
        else begin
            phase = ~phase;
            len = phase ? CPB - 1 : CPB + 1;
        end
    endtask

    task automatic drive_bit(input logic dp, input logic dm);
        int len;
        next_len(len);
        dp_in = dp;
        dm_in = dm;
        repeat (len) @(negedge clk);
    endtask

    // SYNC followed by the bytes of byte_q, LSB first.
    task automatic make_packet();
        data_q.delete();
        for (int i = 0; i < 7; i++) data_q.push_back(1'b0);
        data_q.push_back(1'b1);
        foreach (byte_q[b])
            for (int i = 0; i < 8; i++) data_q.push_back(byte_q[b][i]);
    endtask

    task automatic stuff_wire();
        int run = 0;
        wire_q.delete();
        stuffed_q.delete();
        foreach (data_q[i]) begin
            wire_q.push_back(data_q[i]);
            stuffed_q.push_back(1'b0);
            run = data_q[i] ? run + 1 : 0;
            if (run == 6) begin
                wire_q.push_back(1'b0);
                stuffed_q.push_back(1'b1);
                run = 0;
            end
        end
    endtask

    // NRZI onto the pins (0 = transition), optional 1-bit SE0 before wire index
    // glitch_at, then SE0 x EOPB, then idle J.
    task automatic send_wire(input int glitch_at);
        logic lvl = 1'b1;
        foreach (wire_q[i]) begin
            if (i == glitch_at) drive_bit(1'b0, 1'b0);
            if (!wire_q[i]) lvl = ~lvl;
            drive_bit(lvl, ~lvl);
        end
        repeat (EOPB) drive_bit(1'b0, 1'b0);
        repeat (4) drive_bit(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        n_checks++; if (shift_enable !== 1'b0) begin n_fail++; $display("FAIL reset_shift_enable: got %b expected 0", shift_enable); end
        n_checks++; if (serial_in !== 1'b1) begin n_fail++; $display("FAIL reset_serial_in: got %b expected 1", serial_in); end
        n_checks++; if (eop !== 1'b0) begin n_fail++; $display("FAIL reset_eop: got %b expected 0", eop); end
        n_checks++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_rx_err: got %b expected 0", rx_err); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %b expected 0", rx_busy); end
    endtask

    // K driven before edge t: first strobe must land at t+7, decoded as 0.
    task automatic test_latency_and_mid_reset();
        clear_mon();
        @(negedge clk);
        dp_in = 1'b0; dm_in = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        n_checks++; if (shift_enable !== 1'b0) begin n_fail++; $display("FAIL latency_early: shift_enable %b at t+6, expected 0", shift_enable); end
        @(posedge clk);
        #1;
        n_checks++; if (shift_enable !== 1'b1 || serial_in !== 1'b0) begin n_fail++; $display("FAIL latency_t7: shift_enable %b serial_in %b, expected 1 0", shift_enable, serial_in); end
        @(negedge clk);
        repeat (CPB - 2) @(negedge clk);
        drive_bit(1'b1, 1'b0);
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", rx_busy); end
        rst = 1'b1; dp_in = 1'b1; dm_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (3) drive_bit(1'b1, 1'b0);
        n_checks++; if (got.size() != 0 || err_cnt != 0 || eop_cnt != 0) begin n_fail++; $display("FAIL post_reset_quiet: pulses %0d err %0d eop %0d, expected 0 0 0", got.size(), err_cnt, eop_cnt); end
    endtask

    task automatic test_sync_a5();
        bit exp_bits[$];
        logic [15:0] ref16 = 16'b0000000110100101;
        int bad = -1;
        mode = 0;
        byte_q = '{8'hA5};
        make_packet();
        stuff_wire();
        for (int i = 15; i >= 0; i--) exp_bits.push_back(ref16[i]);
        clear_mon();
        send_wire(-1);
        n_checks++; if (got.size() != 16) begin n_fail++; $display("FAIL a5_count: got %0d pulses expected 16", got.size()); end
        for (int i = 0; i < got.size() && i < 16; i++) if (got[i] != exp_bits[i] && bad < 0) bad = i;
        n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL a5_bits: bit %0d got %b expected %b", bad, got[bad], exp_bits[bad]); end
        n_checks++; if (eop_cnt != 1) begin n_fail++; $display("FAIL a5_eop: got %0d pulses expected 1", eop_cnt); end
        n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL a5_err: got %0d pulses expected 0", err_cnt); end
        n_checks++; if (busy_bad != 0 || rx_busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy: busy_at_eop %0d rx_busy %b expected 0 0", busy_bad, rx_busy); end
        n_checks++; if (min_gap < CPB - 1) begin n_fail++; $display("FAIL a5_gap: min gap %0d expected >= %0d", min_gap, CPB - 1); end
        n_checks++; if (coinc_cnt != 0 || wide_cnt != 0) begin n_fail++; $display("FAIL a5_pulse_shape: coincident %0d wide %0d expected 0 0", coinc_cnt, wide_cnt); end
    endtask

    task automatic test_stuffing();
        int bad = -1;
        mode = 0;
        byte_q = '{8'hFF, 8'h01};
        make_packet();
        stuff_wire();
        clear_mon();
        send_wire(-1);
        n_checks++; if (got.size() != 24) begin n_fail++; $display("FAIL stuff_count: got %0d pulses expected 24", got.size()); end
        for (int i = 0; i < got.size() && i < data_q.size(); i++) if (got[i] != data_q[i] && bad < 0) bad = i;
        n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL stuff_bits: bit %0d got %b expected %b", bad, got[bad], data_q[bad]); end
        n_checks++; if (err_cnt != 0 || eop_cnt != 1) begin n_fail++; $display("FAIL stuff_flags: err %0d eop %0d expected 0 1", err_cnt, eop_cnt); end
        n_checks++; if (min_gap < CPB - 1) begin n_fail++; $display("FAIL stuff_gap: min gap %0d expected >= %0d", min_gap, CPB - 1); end
    endtask

    // Raw wire with no stuffing: SYNC's trailing 1 plus seven 1s violates the rule.
    task automatic test_stuff_error();
        int run = 0;
        int bad = -1;
        bit err_seen = 1'b0;
        mode = 0;
        wire_q.delete();
        for (int i = 0; i < 7; i++) wire_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) wire_q.push_back(1'b1);
        wire_q.push_back(1'b0); wire_q.push_back(1'b1); wire_q.push_back(1'b0);
        data_q.delete();
        foreach (wire_q[i]) begin
            if (!err_seen) begin
                if (run == 6) begin
                    if (wire_q[i]) err_seen = 1'b1;
                    run = 0;
                end else begin
                    data_q.push_back(wire_q[i]);
                    run = wire_q[i] ? run + 1 : 0;
                end
            end
        end
        clear_mon();
        send_wire(-1);
        n_checks++; if (got.size() != data_q.size()) begin n_fail++; $display("FAIL stufferr_count: got %0d pulses expected %0d", got.size(), data_q.size()); end
        for (int i = 0; i < got.size() && i < data_q.size(); i++) if (got[i] != data_q[i] && bad < 0) bad = i;
        n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL stufferr_bits: bit %0d got %b expected %b", bad, got[bad], data_q[bad]); end
        n_checks++; if (err_cnt != 1) begin n_fail++; $display("FAIL stufferr_err: got %0d pulses expected 1", err_cnt); end
        n_checks++; if (eop_cnt != 0) begin n_fail++; $display("FAIL stufferr_eop: got %0d pulses expected 0", eop_cnt); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL stufferr_idle: rx_busy %b expected 0", rx_busy); end
    endtask

    task automatic test_drift();
        int bad = -1;
        mode = 1;
        byte_q.delete();
        for (int i = 0; i < 4; i++) byte_q.push_back(8'($urandom));
        byte_q.push_back(8'hFF);
        make_packet();
        stuff_wire();
        clear_mon();
        send_wire(-1);
        n_checks++; if (got.size() != data_q.size()) begin n_fail++; $display("FAIL drift_count: got %0d pulses expected %0d", got.size(), data_q.size()); end
        for (int i = 0; i < got.size() && i < data_q.size(); i++) if (got[i] != data_q[i] && bad < 0) bad = i;
        n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL drift_bits: bit %0d got %b expected %b", bad, got[bad], data_q[bad]); end
        n_checks++; if (eop_cnt != 1 || err_cnt != 0) begin n_fail++; $display("FAIL drift_flags: eop %0d err %0d expected 1 0", eop_cnt, err_cnt); end
        mode = 0;
    endtask

    task automatic test_se0_glitch();
        int gi, keep = 0;
        int bad = -1;
        mode = 0;
        byte_q = '{8'($urandom), 8'($urandom)};
        make_packet();
        stuff_wire();
        gi = $urandom_range(wire_q.size() - 1, 9);
        for (int i = 0; i < gi; i++) if (!stuffed_q[i]) keep++;
        while (data_q.size() > keep) void'(data_q.pop_back());
        clear_mon();
        send_wire(gi);
        n_checks++; if (got.size() != data_q.size()) begin n_fail++; $display("FAIL glitch_count: got %0d pulses expected %0d (glitch at %0d)", got.size(), data_q.size(), gi); end
        for (int i = 0; i < got.size() && i < data_q.size(); i++) if (got[i] != data_q[i] && bad < 0) bad = i;
        n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL glitch_bits: bit %0d got %b expected %b", bad, got[bad], data_q[bad]); end
        n_checks++; if (err_cnt != 1 || eop_cnt != 0) begin n_fail++; $display("FAIL glitch_flags: err %0d eop %0d expected 1 0", err_cnt, eop_cnt); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: rx_busy %b expected 0", rx_busy); end
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 6; p++) begin
            int bad = -1;
            mode = p % 2;
            byte_q.delete();
            for (int i = 0; i < $urandom_range(4, 1); i++) byte_q.push_back(8'($urandom));
            make_packet();
            stuff_wire();
            clear_mon();
            send_wire(-1);
            for (int i = 0; i < got.size() && i < data_q.size(); i++) if (got[i] != data_q[i] && bad < 0) bad = i;
            n_checks++;
            if (got.size() != data_q.size() || bad >= 0) begin
                n_fail++;
                $display("FAIL b2b_bits pkt %0d: got %0d pulses (first bad %0d) expected %0d", p, got.size(), bad, data_q.size());
            end
            n_checks++;
            if (eop_cnt != 1 || err_cnt != 0 || coinc_cnt != 0 || wide_cnt != 0) begin
                n_fail++;
                $display("FAIL b2b_flags pkt %0d: eop %0d err %0d coinc %0d wide %0d expected 1 0 0 0", p, eop_cnt, err_cnt, coinc_cnt, wide_cnt);
            end
        end
        mode = 0;
    endtask

    initial begin
        rst = 1'b1; dp_in = 1'b1; dm_in = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        test_latency_and_mid_reset();
        test_sync_a5();
        test_stuffing();
        test_stuff_error();
        test_drift();
        test_se0_glitch();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
